// File: rtl/gecko_axi_program_loader.sv
// gecko_axi_program_loader: streams a 32-bit word stream into INCR AXI4 write bursts
// at a programmed base address, never crossing 4 KB, and checks every write response.
module gecko_axi_program_loader #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH/8,
    parameter int ID_WIDTH     = 1,
    parameter int MAX_BURST    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [31:0]             word_count,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic [ID_WIDTH-1:0]     axi_awid,
    output logic [3:0]              axi_awcache,
    output logic                    axi_awlock,
    output logic [2:0]              axi_awprot,
    output logic [3:0]              axi_awqos,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [STROBE_WIDTH-1:0] axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    input  logic [1:0]              axi_bresp,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FINISH} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_remaining;
    logic [7:0]            r_len;
    logic [8:0]            r_cnt;
    logic                  r_awvalid, r_bready, r_busy, r_done, r_error;

    logic [ADDR_WIDTH-1:0] w_base, w_adv_addr;
    logic [31:0]           w_adv_rem;
    logic [8:0]            w_beats;

    // Beats-1 for a burst at byte offset a: limited by words left, MAX_BURST and the 4 KB page end
    function automatic logic [7:0] calc_len(input logic [11:0] a, input logic [31:0] rem);
        logic [31:0] room, b;
        room = 32'((13'h1000 - {1'b0, a}) >> 2);
        b    = (rem < 32'(MAX_BURST)) ? rem : 32'(MAX_BURST);
        b    = (b < room) ? b : room;
        return 8'(b - 32'd1);
    endfunction

    assign w_base     = base_addr & ~ADDR_WIDTH'(3);
    assign w_beats    = {1'b0, r_len} + 9'd1;
    assign w_adv_addr = r_addr + ADDR_WIDTH'({w_beats, 2'b00});
    assign w_adv_rem  = r_remaining - 32'(w_beats);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_addr      <= w_base;
                    r_remaining <= word_count;
                    r_error     <= 1'b0;
                    if (word_count == 32'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_busy    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_len     <= calc_len(w_base[11:0], word_count);
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: if (axi_awready) begin
                    r_awvalid <= 1'b0;
                    r_cnt     <= w_beats;
                    r_state   <= S_DATA;
                end
                S_DATA: if (in_valid && axi_wready) begin
                    r_cnt <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: if (axi_bvalid) begin
                    r_bready <= 1'b0;
                    if (axi_bresp != 2'b00 || w_adv_rem == 32'd0) begin
                        r_error <= r_error | (axi_bresp != 2'b00);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_addr      <= w_adv_addr;
                        r_remaining <= w_adv_rem;
                        r_len       <= calc_len(w_adv_addr[11:0], w_adv_rem);
                        r_awvalid   <= 1'b1;
                        r_state     <= S_ADDR;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign axi_awvalid = r_awvalid;
    assign axi_awaddr  = r_addr;
    assign axi_awlen   = r_len;
    assign axi_awsize  = 3'b010;
    assign axi_awburst = 2'b01;
    assign axi_awid    = '0;
    assign axi_awcache = 4'b0011;
    assign axi_awlock  = 1'b0;
    assign axi_awprot  = 3'b000;
    assign axi_awqos   = 4'b0000;
    // Data channel is a straight pass-through of the input stream while a burst is open
    assign axi_wvalid  = (r_state == S_DATA) && in_valid;
    assign in_ready    = (r_state == S_DATA) && axi_wready;
    assign axi_wdata   = in_data;
    assign axi_wstrb   = '1;
    assign axi_wlast   = (r_state == S_DATA) && (r_cnt == 9'd1);
    assign axi_bready  = r_bready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
endmodule

// File: tb/tb_gecko_axi_program_loader.sv
// tb_gecko_axi_program_loader: directed bench with a small AXI subordinate responder,
// handshake monitor and burst-split reference for the program loader.
module tb_gecko_axi_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        axi_awvalid, axi_awready = 1'b0;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic [0:0]  axi_awid;
    logic [3:0]  axi_awcache;
    logic        axi_awlock;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_awqos;
    logic        axi_wvalid, axi_wready = 1'b0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic [1:0]  axi_bresp = 2'b00;
    logic        busy, done, error;

    always #5 clk = ~clk;

    gecko_axi_program_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awid(axi_awid), .axi_awcache(axi_awcache), .axi_awlock(axi_awlock),
        .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .busy(busy), .done(done), .error(error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    bit          w_last_q[$];
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    int  done_cnt = 0, n_last = 0, word_idx = 0, pend = 0, resp_cnt = 0;
    bit  stall = 0, err_first = 0;
    bit  n_in_hs = 0, n_wlast_hs = 0, n_b_hs = 0;
    bit  p_aw_stall = 0, p_w_stall = 0, p_wlast_hs = 0, p_b_hs = 0, p_wlast = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;
    logic [7:0]  p_awlen = '0;

    // Monitor: handshakes are judged on values held across the negedge before the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (p_aw_stall) check("aw_hold", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, p_awaddr, p_awlen});
            if (p_w_stall) check("w_hold", {axi_wvalid, axi_wdata, axi_wlast}, {1'b1, p_wdata, p_wlast});
            if (p_wlast_hs) check("bready_after_wlast", axi_bready, 1);
            if (p_b_hs) check("after_b", done | axi_awvalid, 1);
            if (axi_awvalid && axi_awready) begin
                aw_addr_q.push_back(axi_awaddr);
                aw_len_q.push_back(axi_awlen);
            end
            if (axi_wvalid && axi_wready) begin
                check("w_after_aw", aw_addr_q.size() > n_last, 1);
                w_data_q.push_back(axi_wdata);
                w_last_q.push_back(axi_wlast);
                if (axi_wlast) n_last++;
            end
            if (done) done_cnt++;
            n_in_hs    = in_valid && in_ready;
            n_wlast_hs = axi_wvalid && axi_wready && axi_wlast;
            n_b_hs     = axi_bvalid && axi_bready;
            p_aw_stall = axi_awvalid && !axi_awready;
            p_w_stall  = axi_wvalid && !axi_wready;
            p_awaddr   = axi_awaddr;
            p_awlen    = axi_awlen;
            p_wdata    = axi_wdata;
            p_wlast    = axi_wlast;
            p_wlast_hs = n_wlast_hs;
            p_b_hs     = n_b_hs;
        end else begin
            {n_in_hs, n_wlast_hs, n_b_hs, p_aw_stall, p_w_stall, p_wlast_hs, p_b_hs} = '0;
        end
    end

    // Subordinate responder and word source, driven just after each active edge
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            pend = 0;
            axi_bvalid = 1'b0;
        end else begin
            if (n_in_hs) word_idx++;
            if (n_wlast_hs) pend++;
            if (n_b_hs) begin
                pend--;
                resp_cnt++;
            end
            if (!axi_bvalid || n_b_hs) begin
                axi_bvalid = (pend > 0) && (!stall || $urandom_range(0, 1) == 1);
                axi_bresp  = (err_first && resp_cnt == 0) ? 2'b10 : 2'b00;
            end
        end
        if (!in_valid || n_in_hs) in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data     = 32'hA500_0000 + 32'(word_idx);
        axi_awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic model(input logic [31:0] base, input int cnt);
        logic [31:0] a;
        int rem, room, b;
        exp_addr_q.delete();
        exp_len_q.delete();
        a = base & ~32'd3;
        rem = cnt;
        while (rem > 0) begin
            room = (4096 - int'(a & 32'hFFF)) / 4;
            b = (rem < 16) ? rem : 16;
            b = (b < room) ? b : room;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(8'(b - 1));
            a = a + 32'(4 * b);
            rem = rem - b;
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, input int cnt, input bit st, input bit ef);
        aw_addr_q.delete();
        aw_len_q.delete();
        w_data_q.delete();
        w_last_q.delete();
        done_cnt = 0;
        n_last = 0;
        resp_cnt = 0;
        word_idx = 0;
        stall = st;
        err_first = ef;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        word_count = 32'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_done", done, cnt == 0);
        check("start_awvalid", axi_awvalid, cnt != 0);
        check("start_busy", busy, cnt != 0);
        check("start_err_clr", error, 0);
    endtask

    task automatic run_job(input logic [31:0] base, input int cnt, input bit st, input bit ef);
        int t;
        pulse_start(base, cnt, st, ef);
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check("done_timeout", done_cnt > 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_once", 64'(done_cnt), 1);
        check("busy_low", busy, 0);
        model(base, cnt);
    endtask

    task automatic verify(input int n);
        int pos, bi;
        check("aw_count", 64'(aw_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < aw_addr_q.size(); i++) begin
            check("awaddr", aw_addr_q[i], exp_addr_q[i]);
            check("awlen", aw_len_q[i], exp_len_q[i]);
        end
        check("w_count", 64'(w_data_q.size()), 64'(n));
        pos = 0;
        bi = 0;
        for (int i = 0; i < w_data_q.size() && i < n; i++) begin
            check("wdata", w_data_q[i], 32'hA500_0000 + 32'(i));
            check("wlast", w_last_q[i], bi < exp_len_q.size() && pos == int'(exp_len_q[bi]));
            if (bi < exp_len_q.size() && pos == int'(exp_len_q[bi])) begin
                pos = 0;
                bi++;
            end else pos++;
        end
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy_done_err", {busy, done, error}, 3'b000);
        check("const_aw", {axi_awsize, axi_awburst, axi_awid, axi_awcache, axi_awlock, axi_awprot, axi_awqos},
              {3'b010, 2'b01, 1'b0, 4'b0011, 1'b0, 3'b000, 4'b0000});
        check("const_wstrb", axi_wstrb, 4'hF);
        @(posedge clk);
        #1 rst = 1'b1;

        run_job(32'h0, 5, 0, 0);
        verify(5);
        check("t1_awlen", aw_len_q[0], 8'd4);
        check("t1_wlast5", {w_last_q[3], w_last_q[4]}, 2'b01);
        check("t1_error", error, 0);

        run_job(32'h0, 40, 0, 0);
        verify(40);
        check("t2_addr", {aw_addr_q[0], aw_addr_q[1], aw_addr_q[2]}, {32'h00, 32'h40, 32'h80});
        check("t2_len", {aw_len_q[0], aw_len_q[1], aw_len_q[2]}, {8'd15, 8'd15, 8'd7});

        run_job(32'hFFB, 4, 0, 0);
        verify(4);
        check("t3_addr", {aw_addr_q[0], aw_addr_q[1]}, {32'hFF8, 32'h1000});
        check("t3_len", {aw_len_q[0], aw_len_q[1]}, {8'd1, 8'd1});

        run_job(32'h0, 40, 0, 1);
        check("err_aw_count", 64'(aw_addr_q.size()), 1);
        check("err_w_count", 64'(w_data_q.size()), 16);
        check("err_flag", error, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_in_ready", {in_ready, axi_awvalid, in_valid}, 3'b001);
        end

        run_job(32'h40, 0, 0, 0);
        check("zero_aw_count", 64'(aw_addr_q.size()), 0);
        check("zero_error", error, 0);

        run_job(32'hF80, 100, 1, 0);
        verify(100);
        check("stall_error", error, 0);
        stall = 0;

        pulse_start(32'h0, 40, 0, 0);
        t = 0;
        while (w_data_q.size() < 5 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("mid_data_reached", w_data_q.size() >= 5, 1);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_outs", {axi_awvalid, axi_wvalid, in_ready, axi_bready, busy, done, error}, 7'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        run_job(32'h100, 3, 0, 0);
        verify(3);
        check("post_rst_len", aw_len_q[0], 8'd2);
        check("post_rst_addr", aw_addr_q[0], 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gecko_axi_program_loader.md
# gecko_axi_program_loader

AXI4 write initiator that streams a program or data image into the gecko compute core's AXI subordinate port, which accepts incoming AXI transactions. It accepts a 32-bit word stream, typically from a host UART/JTAG bridge, and converts it into INCR write bursts starting at a programmed base address. It checks every write response and reports completion or fault. It is write-only; the core's read channels are driven elsewhere.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; fixed 32 in this block
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width
- ID_WIDTH, 1, AXI ID width; awid driven all-zero
- MAX_BURST, 16, maximum beats per burst (1..256)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated 0)
- word_count  in  32  number of 32-bit words to write
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted
- in_data  in  32  input word
- axi_awvalid / axi_awready  out / in  1  write-address handshake
- axi_awaddr  out  ADDR_WIDTH  burst start address
- axi_awlen  out  8  beats-1
- axi_awsize  out  3  constant 3'b010
- axi_awburst  out  2  constant 2'b01 (INCR)
- axi_awid  out  ID_WIDTH  constant 0
- axi_awcache / awlock / awprot / awqos  out  4/1/3/4  constants 4'b0011 / 0 / 3'b000 / 4'b0000
- axi_wvalid / axi_wready  out / in  1  write-data handshake
- axi_wdata  out  32  equals in_data
- axi_wstrb  out  STROBE_WIDTH  all ones
- axi_wlast  out  1  final beat of burst
- axi_bvalid  in  1  response valid
- axi_bready  out  1  response accept
- axi_bresp  in  2  response code; 2'b00 OKAY
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  sticky; set on non-OKAY bresp, cleared on next accepted start

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, FINISH.
- IDLE: on start, latch addr = {base_addr[ADDR_WIDTH-1:2], 2'b00} and remaining = word_count, clear error, and set busy.
  - word_count == 0: go to FINISH.
  - Otherwise: go to ADDR.
- Burst length beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / 4). Bursts never cross a 4 KB boundary.
- ADDR: assert awvalid with awaddr = addr and awlen = beats-1, and hold all AW fields stable until awready. Then go to DATA and load the beat counter.
- DATA: W beats are never issued before the burst's AW is accepted.
  - Pass-through: wvalid = in_valid, in_ready = axi_wready, wdata = in_data.
  - wlast is high when beat counter == 1.
  - The beat counter decrements on each wvalid&wready.
  - After the last beat, go to RESP.
- RESP: bready = 1. On bvalid:
  - bresp != 00: set error and go to FINISH (abort; no further bursts).
  - Otherwise: addr += 4*beats (modulo 2^ADDR_WIDTH) and remaining -= beats; go to FINISH if remaining == 0, else ADDR.
- FINISH: done = 1 for one cycle, busy drops, then go to IDLE.
- start outside IDLE is ignored. in_ready = 0 outside DATA.

## Timing
- Reset (rst low, asynchronous): awvalid, wvalid, bready, in_ready, busy, done and error = 0; FSM = IDLE. Constant AXI fields are static.
- start sampled at edge N: busy = 1 and awvalid = 1 from N+1 (or done = 1 at N+1 if word_count = 0).
- AW handshake at edge M: wvalid may first be high at M+1.
- W beats are zero-bubble; 1 beat/cycle when in_valid and wready are held high.
- Final wlast handshake at edge K: bready = 1 from K+1.
- Last bvalid accepted at edge R: done = 1 and busy = 0 during cycle R+1. A new start is accepted from R+2.
- Reset mid-transaction: outputs drop immediately. A partial AXI burst is abandoned, and the downstream subordinate is reset in the same domain.

## Test plan
- base 0x0, count 5, wready/in_valid always high → one AW with awlen=4; 5 contiguous beats with wlast on the 5th; bresp OKAY → done pulse, error=0.
- base 0x0, count 40 → three bursts: awaddr 0x00/0x40/0x80, awlen 15/15/7; data order preserved; exactly one done.
- base 0xFF8, count 4 → bursts at 0xFF8 (awlen=1) and 0x1000 (awlen=1); no 4 KB crossing.
- count 40, first bresp=2'b10 → error=1, done pulse, only one AW issued, in_ready stays 0 afterward.
- count 0 → done at the cycle after start; awvalid never asserted.
- Random wready/in_valid/awready/bvalid stalls with count 100 → all 100 words written in order, AW/W fields stable while stalled. Reset asserted mid-DATA, then count 3 → clean single burst, awlen=2.
